instr_fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core. Holds the program counter, issues one word-aligned request at a time to instruction memory and waits for a variable-latency response. Presents the fetched instruction and its PC to decode through a valid/stall handshake. The control unit consumes `if_opcode`. Taken-branch redirects from execute discard stale or in-flight instructions.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word fetch, valid/stall handoff to decode,
// taken-branch redirects squash held or in-flight instructions.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode
);

  localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h3;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] addr_nxt, instr_nxt, ifpc_nxt, tgt;
  logic        req_nxt, valid_nxt;

  assign tgt       = branch_target & ~32'h3;
  assign if_opcode = if_instr[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= BOOT_PC;
      imem_req  <= 1'b0;
      imem_addr <= BOOT_PC;
      if_valid  <= 1'b0;
      if_instr  <= NOP;
      if_pc     <= BOOT_PC;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
      if_valid  <= valid_nxt;
      if_instr  <= instr_nxt;
      if_pc     <= ifpc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = imem_req;
    addr_nxt  = imem_addr;
    valid_nxt = if_valid;
    instr_nxt = if_instr;
    ifpc_nxt  = if_pc;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
        req_nxt   = 1'b1;
        if (branch_taken) begin
          pc_nxt   = tgt;
          addr_nxt = tgt;
        end else begin
          addr_nxt = pc;
        end
      end

      FETCH: begin
        if (branch_taken) begin
          pc_nxt = tgt;
          if (imem_rvalid) begin
            // Response consumed and dropped; the redirect is issued on the same edge.
            addr_nxt = tgt;
          end else begin
            req_nxt   = 1'b0;
            state_nxt = FLUSH;
          end
        end else if (imem_rvalid) begin
          instr_nxt = imem_rdata;
          ifpc_nxt  = imem_addr;
          valid_nxt = 1'b1;
          pc_nxt    = imem_addr + 32'd4;
          req_nxt   = 1'b0;
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        if (branch_taken || !stall) begin
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          state_nxt = FETCH;
          if (branch_taken) begin
            pc_nxt   = tgt;
            addr_nxt = tgt;
          end else begin
            addr_nxt = pc;
          end
        end
      end

      FLUSH: begin
        // The old request is still in flight; only its response frees the bus.
        if (branch_taken) pc_nxt = tgt;
        if (imem_rvalid) begin
          req_nxt   = 1'b1;
          addr_nxt  = branch_taken ? tgt : pc;
          state_nxt = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a negedge-driven memory model with adjustable
// latency serves the main instance; a second instance checks a non-zero reset PC.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;

  logic        rst_b_n;
  logic        imem_req_b;
  logic [31:0] imem_addr_b;
  logic        imem_rvalid_b;
  logic [31:0] imem_rdata_b;
  logic        if_valid_b;
  logic [31:0] if_instr_b;
  logic [31:0] if_pc_b;
  logic [6:0]  if_opcode_b;

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode)
  );

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut_b (
    .clk(clk), .rst_n(rst_b_n),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_rvalid(imem_rvalid_b), .imem_rdata(imem_rdata_b),
    .branch_taken(1'b0), .branch_target(32'h0),
    .stall(1'b0),
    .if_valid(if_valid_b), .if_instr(if_instr_b), .if_pc(if_pc_b), .if_opcode(if_opcode_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: sees a request on a negedge, answers `lat` negedges later with {addr[31:2],2'b11}.
  initial begin
    int          cnt;
    logic        busy;
    logic [31:0] maddr;
    cnt = 0; busy = 1'b0; maddr = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_rvalid = 1'b0;
        busy        = 1'b0;
      end else begin
        if (imem_rvalid) imem_rvalid = 1'b0;
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = {maddr[31:2], 2'b11};
            busy        = 1'b0;
          end
        end else if (imem_req) begin
          busy  = 1'b1;
          cnt   = lat;
          maddr = imem_addr;
        end
      end
    end
  end

  initial begin
    logic [8:0]  exp_v;
    logic [31:0] exp_a [3];
    exp_v = 9'b100100100;
    exp_a = '{32'h0, 32'h4, 32'h8};

    rst_n = 1'b0; rst_b_n = 1'b0;
    branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
    imem_rvalid_b = 1'b0; imem_rdata_b = '0;
    repeat (2) @(negedge clk);

    check("rst_req",    32'(imem_req), 0);
    check("rst_addr",   imem_addr, 32'h0);
    check("rst_valid",  32'(if_valid), 0);
    check("rst_instr",  if_instr, 32'h13);
    check("rst_pc",     if_pc, 32'h0);
    check("rst_opcode", 32'(if_opcode), 32'h13);
    check("rstb_addr",  imem_addr_b, 32'h100);
    check("rstb_pc",    if_pc_b, 32'h100);

    // Non-zero reset PC, 4-cycle memory on the second instance.
    rst_b_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("b_req", 32'(imem_req_b), 1);
        check("b_addr", imem_addr_b, 32'h100);
      end
      if (i == 4) begin
        check("b_valid_early", 32'(if_valid_b), 0);
        imem_rvalid_b = 1'b1;
        imem_rdata_b  = 32'h0000_A0B3;
      end
      if (i == 5) begin
        imem_rvalid_b = 1'b0;
        check("b_valid", 32'(if_valid_b), 1);
        check("b_pc", if_pc_b, 32'h100);
        check("b_instr", if_instr_b, 32'h0000_A0B3);
        check("b_opcode", 32'(if_opcode_b), 32'h33);
      end
    end

    // Back-to-back fetches with a 1-cycle memory.
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("tp_valid", 32'(if_valid), 32'(exp_v[i]));
      if (i % 3 == 0) begin
        check("tp_req", 32'(imem_req), 1);
        check("tp_addr", imem_addr, exp_a[i/3]);
      end
      if (exp_v[i]) begin
        check("tp_pc", if_pc, exp_a[i/3]);
        check("tp_instr", if_instr, exp_a[i/3] | 32'h3);
      end
    end

    // Stall holds the instruction and blocks the next request.
    stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("st_valid", 32'(if_valid), 1);
      check("st_pc", if_pc, 32'h8);
      check("st_instr", if_instr, 32'hB);
      check("st_req", 32'(imem_req), 0);
    end
    stall = 1'b0;
    lat   = 3;
    @(negedge clk);
    check("st_rel_req", 32'(imem_req), 1);
    check("st_rel_addr", imem_addr, 32'hC);

    // Redirect two cycles ahead of the response: flush, then fetch 0x200.
    @(negedge clk);
    branch_taken = 1'b1; branch_target = 32'h203;
    @(negedge clk);
    branch_taken = 1'b0;
    check("fl_req", 32'(imem_req), 0);
    check("fl_valid1", 32'(if_valid), 0);
    @(negedge clk);
    check("fl_valid2", 32'(if_valid), 0);
    lat = 1;
    @(negedge clk);
    check("fl_valid3", 32'(if_valid), 0);
    check("fl_req2", 32'(imem_req), 1);
    check("fl_addr", imem_addr, 32'h200);

    // Redirect coincident with a response, then another into FLUSH.
    @(negedge clk);
    branch_taken = 1'b1; branch_target = 32'h300;
    lat = 4;
    @(negedge clk);
    check("co_valid", 32'(if_valid), 0);
    check("co_req", 32'(imem_req), 1);
    check("co_addr", imem_addr, 32'h300);
    branch_target = 32'h400;
    @(negedge clk);
    branch_taken = 1'b0;
    check("co_flush_req", 32'(imem_req), 0);
    @(negedge clk);
    branch_taken = 1'b1; branch_target = 32'h500;
    @(negedge clk);
    branch_taken = 1'b0;
    @(negedge clk);
    check("co_valid2", 32'(if_valid), 0);
    lat = 1;
    @(negedge clk);
    check("co_req2", 32'(imem_req), 1);
    check("co_addr2", imem_addr, 32'h500);
    repeat (2) @(negedge clk);
    check("co_valid3", 32'(if_valid), 1);
    check("co_pc", if_pc, 32'h500);
    check("co_instr", if_instr, 32'h503);

    // Redirect from HOLD to the top word, low target bits ignored; PC wraps.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    @(negedge clk);
    branch_taken = 1'b0;
    check("wr_valid", 32'(if_valid), 0);
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    check("wr_pc", if_pc, 32'hFFFF_FFFC);
    check("wr_instr", if_instr, 32'hFFFF_FFFF);
    @(negedge clk);
    check("wr_req", 32'(imem_req), 1);
    check("wr_next", imem_addr, 32'h0);

    // Asynchronous reset mid-fetch.
    #2 rst_n = 1'b0;
    #1;
    check("ar_req", 32'(imem_req), 0);
    check("ar_valid", 32'(if_valid), 0);
    check("ar_pc", if_pc, 32'h0);
    check("ar_instr", if_instr, 32'h13);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_restart_req", 32'(imem_req), 1);
    check("ar_restart_addr", imem_addr, 32'h0);
    repeat (2) @(negedge clk);
    check("ar_valid2", 32'(if_valid), 1);
    check("ar_pc2", if_pc, 32'h0);
    check("ar_instr2", if_instr, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
